// File: rtl/axis_fifo_pkt.sv
// AXI-Stream circular-buffer FIFO with tlast framing and optional store-and-forward packet mode.
// Provides a live occupancy count, a count of stored frames and almost-full/almost-empty flags.
module axis_fifo_pkt #(
   parameter int abits       = 7,
   parameter int dbits       = 64,
   parameter int packet_mode = 0,
   parameter int af_level    = 2**abits - 4,
   parameter int ae_level    = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [dbits-1:0] din,
   input  logic             s_axis_tvalid,
   input  logic             s_axis_tlast,
   output logic             s_axis_tready,
   output logic [dbits-1:0] dout,
   output logic             m_axis_tvalid,
   output logic             m_axis_tlast,
   input  logic             m_axis_tready,
   output logic [abits:0]   level,
   output logic [abits:0]   pkt_count,
   output logic             almost_full,
   output logic             almost_empty
);

   localparam int             depth   = 2**abits;
   localparam logic [abits:0] depth_c = (abits+1)'(depth);
   localparam logic [abits:0] af_c    = (abits+1)'(af_level);
   localparam logic [abits:0] ae_c    = (abits+1)'(ae_level);

   if (!((ae_level < af_level) && (af_level <= depth))) begin : g_param_check
      $error("axis_fifo_pkt: thresholds must satisfy ae_level < af_level <= 2**abits");
   end

   logic [dbits:0]   mem [depth];
   logic [abits-1:0] wp;
   logic [abits-1:0] rp;
   logic [abits:0]   level_q;
   logic [abits:0]   pkt_q;
   logic             is_full;
   logic             is_empty;
   logic             wr_en;
   logic             rd_en;
   logic             head_last;

   assign is_full   = (level_q == depth_c);
   assign is_empty  = (level_q == '0);
   assign head_last = mem[rp][dbits];

   assign s_axis_tready = reset && !is_full;
   assign wr_en         = s_axis_tvalid && s_axis_tready;
   assign rd_en         = m_axis_tvalid && m_axis_tready;

   assign dout         = mem[rp][dbits-1:0];
   assign m_axis_tlast = head_last;

   // In packet mode the head is held back until a whole frame is buffered, unless
   // the FIFO is full with no tlast inside, which would otherwise deadlock.
   always_comb begin
      m_axis_tvalid = 1'b0;
      if (reset && !is_empty) begin
         if (packet_mode == 0) begin
            m_axis_tvalid = 1'b1;
         end else begin
            m_axis_tvalid = (pkt_q != '0) || is_full;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wp] <= {s_axis_tlast, din};
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (wr_en) begin
            wp <= wp + 1'b1;
         end
         if (rd_en) begin
            rp <= rp + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         level_q <= '0;
      end else begin
         case ({wr_en, rd_en})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   // A frame is counted when its tlast word enters and released when that word leaves.
   always_ff @(posedge clock) begin
      if (!reset) begin
         pkt_q <= '0;
      end else begin
         case ({wr_en && s_axis_tlast, rd_en && head_last})
            2'b10:   pkt_q <= pkt_q + 1'b1;
            2'b01:   pkt_q <= pkt_q - 1'b1;
            default: pkt_q <= pkt_q;
         endcase
      end
   end

   assign level        = level_q;
   assign pkt_count    = pkt_q;
   assign almost_full  = reset && (level_q >= af_c);
   assign almost_empty = !reset || (level_q <= ae_c);

endmodule
